acc_sequencer: RTL
==================

# acc_sequencer

Instruction sequencer for the Aiva accumulator datapath. It fetches 24-bit instruction words from an instruction memory over a req/valid handshake and decodes them. It drives the accumulator's `acc_en`, `opcode`, `op_rdy` and `acc_data_in` one operation at a time, and resolves jumps using the accumulator's `acc_out`. It sits between the instruction memory and the accumulator and is the only master of the accumulator's control inputs.

## Interface
- `PC_W`, 8, program counter and instruction address width
- `OP_W`, 24, opcode/instruction word width
- `DATA_W`, 8, accumulator data width
- `clk  in  1  system clock, rising edge`
- `seq_rst_n  in  1  asynchronous active-low reset`
- `start  in  1  begin execution at address 0; honoured only in IDLE/HALT`
- `busy  out  1  high in every state except IDLE and HALT`
- `halted  out  1  high in HALT`
- `illegal  out  1  one-cycle pulse in DECODE on an unknown opcode`
- `pc  out  PC_W  current program counter`
- `imem_req  out  1  instruction fetch request`
- `imem_addr  out  PC_W  fetch address; stable while imem_req is high`
- `imem_valid  in  1  fetch data valid`
- `imem_data  in  OP_W  fetched word`
- `acc_rst  out  1  accumulator clear, active high`
- `acc_en  out  1  accumulator enable`
- `op_rdy  out  1  operation strobe`
- `opcode  out  OP_W  operation to accumulator`
- `acc_data_in  out  DATA_W  load operand to accumulator`
- `acc_out  in  DATA_W  accumulator value, used by JNZ`

## Operation
- Opcodes are the 24-bit words OP_NOP=24'h000000, OP_LDA=24'h4C4441, OP_INC=24'h494E43, OP_DEC=24'h444543, OP_JMP=24'h4A4D50, OP_JNZ=24'h4A4E5A and OP_HLT=24'h484C54.
- LDA, JMP and JNZ are two-word instructions. The second word is an operand, and only bits [7:0] of it are used.
- States are IDLE, FETCH, DECODE, OPER, EXEC and HALT.
- IDLE/HALT with `start`: for one cycle, `acc_rst`=1, `pc`<=0, state -> FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_valid`, latch `imem_data` into the instruction register, `pc`<=`pc`+1, state -> DECODE.
- DECODE:
  - NOP -> FETCH.
  - HLT -> HALT.
  - INC/DEC -> EXEC.
  - LDA/JMP/JNZ -> OPER.
  - Any other word: pulse `illegal`, treat as NOP.
- OPER: fetch at `pc` with the same handshake as FETCH. On `imem_valid`:
  - `pc`<=`pc`+1.
  - LDA: latch operand[7:0] into `acc_data_in`, state -> EXEC.
  - JMP: `pc`<=operand[7:0], state -> FETCH.
  - JNZ: if `acc_out`!=0 then `pc`<=operand[7:0], else keep `pc`+1; state -> FETCH.
- EXEC: `acc_en`=1, `op_rdy`=1, `opcode`=decoded constant, for exactly one cycle; state -> FETCH.
- `pc` increments modulo 2^PC_W, so 8'hFF+1 = 8'h00. A jump target of 8'hFF is legal.
- `start` while busy is ignored.
- `imem_valid` is ignored outside FETCH/OPER.
- Reset mid-operation aborts immediately. All outputs go to reset values asynchronously, and a pending fetch is abandoned.

## Timing
- Reset values:
  - state IDLE; `pc`=0, `opcode`=OP_NOP, `acc_data_in`=0.
  - `imem_req`, `acc_en`, `op_rdy`, `acc_rst`, `busy`, `halted` and `illegal` all 0.
- Control outputs `imem_req`, `acc_en`, `op_rdy`, `busy` and `halted` decode from state. All other outputs are registered.
- Zero-wait memory (`imem_valid` high in the same cycle as `imem_req`): NOP takes 2 cycles, INC/DEC 3, LDA 4, JMP/JNZ 3, HLT 2 to HALT.
- Each wait cycle in FETCH or OPER adds one cycle. `imem_addr` is held stable throughout.
- The accumulator updates on the EXEC clock edge. `acc_out` is valid at least 2 cycles before any following JNZ samples it in OPER.
- `opcode` and `acc_data_in` hold their last values outside EXEC.

## Structure
- Shared package `aiva_pkg` holds:
  - The seven OP_* constants. The accumulator adopts the same constants in place of its local parameters.
  - The state enum.
  - The operand field slice [7:0].
- One natural sub-module: `acc_fetch_if`, the req/valid fetch handshake shared by FETCH and OPER.

## Test plan
- Reset: assert `seq_rst_n`=0 mid-run -> all outputs at reset values within the same cycle, state IDLE, `pc`=0.
- Basic program, zero-wait memory. Program: LDA 0x05, INC, HLT. Response:
  - `acc_rst` pulses on `start`.
  - EXEC strobes carry OP_LDA with `acc_data_in`=0x05, then OP_INC.
  - `halted`=1 after 9 cycles.
- Loop. Program: 0:LDA 3, 2:DEC, 3:JNZ 2, 5:HLT. Response:
  - Exactly three OP_DEC strobes.
  - The final JNZ falls through with `pc`=5, then HALT.
- Wait states: `imem_valid` delayed 3 cycles on every fetch -> `imem_addr` stable throughout, and each instruction is 3 cycles per fetch longer than the zero-wait counts.
- Illegal opcode: word 24'h123456 -> one-cycle `illegal` pulse, no `acc_en`, execution continues at `pc`+1.
- PC wrap. Program: JMP 0xFF with a NOP at 0xFF -> next fetch at `imem_addr`=0x00.
- Abort: reset during OPER of an LDA -> no `op_rdy`, and a late `imem_valid` is ignored after reset.

Source files
------------

// File: rtl/aiva_pkg.sv
// aiva_pkg: opcodes, sequencer states and operand field shared by the Aiva accumulator datapath
package aiva_pkg;
  localparam logic [23:0] OP_NOP = 24'h000000;
  localparam logic [23:0] OP_LDA = 24'h4C4441;
  localparam logic [23:0] OP_INC = 24'h494E43;
  localparam logic [23:0] OP_DEC = 24'h444543;
  localparam logic [23:0] OP_JMP = 24'h4A4D50;
  localparam logic [23:0] OP_JNZ = 24'h4A4E5A;
  localparam logic [23:0] OP_HLT = 24'h484C54;
  localparam int OPND_MSB = 7;
  localparam int OPND_LSB = 0;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_OPER, S_EXEC, S_HALT} state_t;
  function automatic logic known_op(input logic [23:0] w);
    return w inside {OP_NOP, OP_LDA, OP_INC, OP_DEC, OP_JMP, OP_JNZ, OP_HLT};
  endfunction
  function automatic logic has_operand(input logic [23:0] w);
    return w inside {OP_LDA, OP_JMP, OP_JNZ};
  endfunction
endpackage

// File: rtl/acc_fetch_if.sv
// acc_fetch_if: req/valid instruction fetch handshake shared by the FETCH and OPER states
module acc_fetch_if #(
  parameter int PC_W = 8,
  parameter int OP_W = 24
) (
  input  logic            active,
  input  logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [OP_W-1:0] imem_data,
  output logic            done,
  output logic [OP_W-1:0] word
);
  // pc only moves when a fetch completes, so the address is stable across wait cycles
  assign imem_req  = active;
  assign imem_addr = pc;
  assign done      = active && imem_valid;
  assign word      = imem_data;
endmodule

// File: rtl/acc_sequencer.sv
// acc_sequencer: fetches and decodes instruction words and drives the accumulator one operation at a time
module acc_sequencer
  import aiva_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int OP_W   = 24,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              seq_rst_n,
  input  logic              start,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [PC_W-1:0]   pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [OP_W-1:0]   imem_data,
  output logic              acc_rst,
  output logic              acc_en,
  output logic              op_rdy,
  output logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] acc_data_in,
  input  logic [DATA_W-1:0] acc_out
);
  state_t state;
  logic [OP_W-1:0] ir;
  logic [OP_W-1:0] fetch_word;
  logic fetch_done;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  logic take_jump;
  acc_fetch_if #(.PC_W(PC_W), .OP_W(OP_W)) u_fetch (
    .active     (state == S_FETCH || state == S_OPER),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .done       (fetch_done),
    .word       (fetch_word)
  );
  assign busy      = !(state == S_IDLE || state == S_HALT);
  assign halted    = state == S_HALT;
  assign acc_en    = state == S_EXEC;
  assign op_rdy    = state == S_EXEC;
  assign pc_inc    = pc + 1'b1;
  assign target    = PC_W'(fetch_word[OPND_MSB:OPND_LSB]);
  assign take_jump = ir == OP_JMP || (ir == OP_JNZ && acc_out != '0);
  always_ff @(posedge clk or negedge seq_rst_n) begin
    if (!seq_rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= OP_NOP;
      opcode      <= OP_NOP;
      acc_data_in <= '0;
      acc_rst     <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      acc_rst <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE, S_HALT: if (start) begin
          acc_rst <= 1'b1;
          pc      <= '0;
          state   <= S_FETCH;
        end
        S_FETCH: if (fetch_done) begin
          ir      <= fetch_word;
          pc      <= pc_inc;
          illegal <= !known_op(fetch_word);
          state   <= S_DECODE;
        end
        S_DECODE: begin
          if (ir == OP_INC || ir == OP_DEC) opcode <= ir;
          state <= ir == OP_HLT ? S_HALT :
                   (ir == OP_INC || ir == OP_DEC) ? S_EXEC :
                   has_operand(ir) ? S_OPER : S_FETCH;
        end
        S_OPER: if (fetch_done) begin
          pc <= take_jump ? target : pc_inc;
          if (ir == OP_LDA) begin
            acc_data_in <= DATA_W'(fetch_word[OPND_MSB:OPND_LSB]);
            opcode      <= OP_LDA;
          end
          state <= ir == OP_LDA ? S_EXEC : S_FETCH;
        end
        S_EXEC: state <= S_FETCH;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
